// File: rtl/ble_cmd_responder.sv
// BLE/UART command link endpoint: receives 8N1 byte pairs as 16-bit commands
// and transmits 8-bit status responses.
module ble_cmd_responder #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int CW = $clog2(BAUD_DIV) + 1;
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [0:0] WAIT_HI = 1'b0;
  localparam logic [0:0] WAIT_LO = 1'b1;

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_XMIT = 1'b1;

  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bits;
  logic [7:0]    rx_shift;
  logic          rx_tick, rx_fall, start_ok, byte_done, frame_err;

  logic [0:0]    asm_state;
  logic [7:0]    hi_byte;

  logic [0:0]    tx_state;
  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bits;

  assign rx_tick   = (rx_cnt == '0);
  assign rx_fall   = rx_prev & ~rx_sync;
  assign start_ok  = (rx_state == RX_START) && rx_tick && !rx_sync;
  assign byte_done = (rx_state == RX_STOP) && rx_tick && rx_sync;
  assign frame_err = (rx_state == RX_STOP) && rx_tick && !rx_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_BIT;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
            rx_cnt   <= FULL_BIT;
            rx_bits  <= '0;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= FULL_BIT;
            rx_bits  <= rx_bits + 1'b1;
            if (rx_bits == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: begin
          if (rx_tick) rx_state <= RX_IDLE;
          else         rx_cnt   <= rx_cnt - 1'b1;
        end
      endcase
    end
  end

  // A set from the completing low byte outranks any clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_state <= WAIT_HI;
      hi_byte   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      if (byte_done) begin
        if (asm_state == WAIT_HI) begin
          hi_byte   <= rx_shift;
          asm_state <= WAIT_LO;
        end else begin
          cmd       <= {hi_byte, rx_shift};
          asm_state <= WAIT_HI;
        end
      end else if (frame_err) begin
        asm_state <= WAIT_HI;
      end

      if (byte_done && asm_state == WAIT_LO)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || (start_ok && asm_state == WAIT_HI))
        cmd_rdy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_shift  <= '1;
      tx_cnt    <= '0;
      tx_bits   <= '0;
      TX        <= 1'b1;
      resp_sent <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_shift  <= {1'b1, resp, 1'b0};
            TX        <= 1'b0;
            tx_cnt    <= FULL_BIT;
            tx_bits   <= '0;
            resp_sent <= 1'b0;
            tx_state  <= TX_XMIT;
          end
        end
        default: begin
          if (tx_cnt == '0) begin
            if (tx_bits == 4'd9) begin
              tx_state  <= TX_IDLE;
              TX        <= 1'b1;
              resp_sent <= 1'b1;
            end else begin
              tx_shift <= {1'b1, tx_shift[9:1]};
              TX       <= tx_shift[1];
              tx_bits  <= tx_bits + 1'b1;
              tx_cnt   <= FULL_BIT;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ble_cmd_responder.sv
// Scoreboard bench for ble_cmd_responder at 16 clocks per bit.
module tb_ble_cmd_responder;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_cmd[$];
  logic [7:0]  exp_resp[$];
  logic        prev_rdy;
  logic        tx_prev = 1'b1;
  logic        tx_mon_en = 1'b1;

  ble_cmd_responder #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  // command monitor: each rising cmd_rdy must match the oldest expected command
  initial begin
    logic [15:0] e;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && prev_rdy !== 1'b1) begin
        if (exp_cmd.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cmd: got %h want none", cmd);
        end else begin
          e = exp_cmd.pop_front();
          chk("cmd", {16'h0, cmd}, {16'h0, e});
        end
      end
      prev_rdy = cmd_rdy;
    end
  end

  // response monitor: decodes TX frames at mid-bit
  initial begin
    logic [7:0] d;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_mon_en && tx_prev === 1'b1 && TX === 1'b0) begin
        repeat (BD / 2) @(negedge clk);
        chk("tx_start", {31'h0, TX}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          d[i] = TX;
        end
        repeat (BD) @(negedge clk);
        chk("tx_stop", {31'h0, TX}, 32'h1);
        if (exp_resp.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: got %h want none", d);
        end else begin
          e = exp_resp.pop_front();
          chk("resp_byte", {24'h0, d}, {24'h0, e});
        end
      end
      tx_prev = TX;
    end
  end

  initial begin
    logic [9:0] eb;
    int tx_err;
    int rs_err;

    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, TX}, 32'h1);
    chk("rst_cmd", {16'h0, cmd}, 32'h0);
    chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("rst_resp_sent", {31'h0, resp_sent}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // tour command, held until cleared
    exp_cmd.push_back(16'h4022);
    send_byte(8'h40, 1'b1);
    send_byte(8'h22, 1'b1);
    chk("tour_rdy", {31'h0, cmd_rdy}, 32'h1);
    repeat (50) @(negedge clk);
    chk("tour_rdy_held", {31'h0, cmd_rdy}, 32'h1);
    pulse_clr();
    chk("tour_rdy_clr", {31'h0, cmd_rdy}, 32'h0);

    // move command, then calibrate without a clear
    exp_cmd.push_back(16'h33F2);
    send_byte(8'h33, 1'b1);
    send_byte(8'hF2, 1'b1);
    chk("move_rdy", {31'h0, cmd_rdy}, 32'h1);
    chk("move_cmd", {16'h0, cmd}, 32'h33F2);
    exp_cmd.push_back(16'h0000);
    send_byte(8'h00, 1'b1);
    chk("cal_rdy_dropped", {31'h0, cmd_rdy}, 32'h0);
    chk("cal_cmd_kept", {16'h0, cmd}, 32'h33F2);
    send_byte(8'h00, 1'b1);
    chk("cal_rdy", {31'h0, cmd_rdy}, 32'h1);
    pulse_clr();

    // response A5, with an ignored second request mid-frame
    eb = {1'b1, 8'hA5, 1'b0};
    exp_resp.push_back(8'hA5);
    tx_err = 0;
    rs_err = 0;
    resp = 8'hA5;
    send_resp = 1'b1;
    for (int i = 1; i <= 10 * BD + 1; i++) begin
      @(negedge clk);
      if (i == 1)  send_resp = 1'b0;
      if (i == 40) begin resp = 8'h5A; send_resp = 1'b1; end
      if (i == 41) send_resp = 1'b0;
      if (i <= 10 * BD) begin
        if (TX !== eb[(i - 1) / BD]) tx_err++;
        if (resp_sent !== 1'b0) rs_err++;
      end else begin
        chk("resp_sent_160", {31'h0, resp_sent}, 32'h1);
        chk("tx_idle_160", {31'h0, TX}, 32'h1);
      end
    end
    chk("tx_bit_errors", tx_err, 0);
    chk("resp_sent_early", rs_err, 0);
    repeat (3 * BD) @(negedge clk);
    chk("resp_sent_held", {31'h0, resp_sent}, 32'h1);

    // glitch rejection
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (3 * BD) @(negedge clk);
    chk("glitch_rdy", {31'h0, cmd_rdy}, 32'h0);

    // framing error on a high byte, then a clean command
    send_byte(8'h40, 1'b0);
    repeat (BD) @(negedge clk);
    chk("frame_rdy", {31'h0, cmd_rdy}, 32'h0);
    exp_cmd.push_back(16'h4022);
    send_byte(8'h40, 1'b1);
    send_byte(8'h22, 1'b1);
    chk("frame_cmd", {16'h0, cmd}, 32'h4022);
    pulse_clr();

    // concurrent receive and transmit
    exp_cmd.push_back(16'h4022);
    exp_resp.push_back(8'h5A);
    fork
      begin
        send_byte(8'h40, 1'b1);
        send_byte(8'h22, 1'b1);
      end
      begin
        repeat (30) @(negedge clk);
        resp = 8'h5A;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
      end
    join
    for (int i = 0; i < 400 && resp_sent !== 1'b1; i++) @(negedge clk);
    chk("conc_resp_sent", {31'h0, resp_sent}, 32'h1);
    chk("conc_cmd", {16'h0, cmd}, 32'h4022);
    chk("conc_rdy", {31'h0, cmd_rdy}, 32'h1);

    // reset mid-byte with a response in flight
    send_byte(8'h12, 1'b1);
    tx_mon_en = 1'b0;
    RX = 1'b0;
    resp = 8'h5A;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (BD + 4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", {31'h0, TX}, 32'h1);
    chk("mid_rst_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("mid_rst_resp_sent", {31'h0, resp_sent}, 32'h0);
    chk("mid_rst_cmd", {16'h0, cmd}, 32'h0);
    rst_n = 1'b1;
    RX = 1'b1;
    repeat (3 * BD) @(negedge clk);
    tx_mon_en = 1'b1;
    exp_cmd.push_back(16'h5678);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    chk("post_rst_cmd", {16'h0, cmd}, 32'h5678);
    chk("post_rst_rdy", {31'h0, cmd_rdy}, 32'h1);

    repeat (2 * BD) @(negedge clk);
    chk("cmd_queue_empty", exp_cmd.size(), 0);
    chk("resp_queue_empty", exp_resp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ble_cmd_responder.md
# ble_cmd_responder

Knight-side end of the BLE/UART command link. It deserializes 8N1 bytes arriving on `RX` and assembles each pair into a 16-bit command (high byte first), presenting it to the command processor with a `cmd_rdy`/`clr_cmd_rdy` handshake. It serializes 8-bit status responses (`8'hA5` complete, `8'h5A` intermediate) back onto `TX`. It sits between the BLE module pins and the command FSM, mirroring the remote command sender used by the bench.

## Interface
- `BAUD_DIV`, default 2604: clocks per bit, 19200 baud at 50 MHz. Must be ≥ 8.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `RX` in 1: serial input, idle high, asynchronous to `clk`.
- `TX` out 1: serial output, idle high.
- `cmd` out 16: last complete command, `{byte0, byte1}`.
- `cmd_rdy` out 1: a new command is valid on `cmd`.
- `clr_cmd_rdy` in 1: the consumer has taken `cmd`.
- `resp` in 8: response byte to send.
- `send_resp` in 1: one-cycle request to transmit `resp`.
- `resp_sent` out 1: level. The last response has finished, stop bit included.

## Operation
- Reset values: `TX`=1, `cmd`=0, `cmd_rdy`=0, `resp_sent`=0. The RX synchronizer flops reset to 1. All FSMs return to IDLE and all counters clear.
- RX path uses a 2-flop synchronizer. Falling-edge detect is taken on the synchronized signal.
- RX FSM states are IDLE, START, DATA and STOP.
  - IDLE→START on a falling edge. The baud counter loads `BAUD_DIV/2`.
  - START samples at counter expiry. If the sample is 1, the start was a glitch and the FSM returns to IDLE. Otherwise it moves to DATA.
  - DATA takes 8 samples spaced `BAUD_DIV` apart, LSB first, into a shift register.
  - STOP takes one sample. If it is 1, `byte_done` pulses for one cycle. If it is 0, this is a framing error: the byte is discarded and no pulse is issued.
  - Either way the FSM goes to IDLE.
- Assembly FSM states are WAIT_HI and WAIT_LO.
  - A `byte_done` in WAIT_HI latches the high byte and moves to WAIT_LO.
  - A `byte_done` in WAIT_LO writes `cmd = {hi, byte}`, sets `cmd_rdy` and returns to WAIT_HI.
  - A framing error in WAIT_LO returns to WAIT_HI, and the half command is dropped.
- `cmd_rdy` clear rules:
  - It clears on `clr_cmd_rdy`.
  - It also clears on a valid start bit detected while in WAIT_HI.
  - If a set and a clear occur in the same cycle, set wins.
- `cmd` changes only when `cmd_rdy` is set.
- TX FSM states are IDLE and XMIT.
  - `send_resp` in IDLE loads `{1'b1, resp, 1'b0}` into a 10-bit shift register and clears `resp_sent`.
  - Each bit is held for `BAUD_DIV` clocks, LSB (start bit) first.
  - After the 10th bit period the FSM returns to IDLE and sets `resp_sent`. It holds that level until the next accepted `send_resp`.
  - `send_resp` during XMIT is ignored.
- RX and TX are fully independent and may run simultaneously.

## Timing
- `TX` goes low on the first edge after `send_resp` is sampled in IDLE.
- `resp_sent` rises exactly `10*BAUD_DIV` cycles after the `send_resp` edge, and `TX` is 1 at that point.
- Start-bit sample point is `BAUD_DIV/2` cycles after the synchronized falling edge, plus 2 cycles of synchronizer latency.
- Data bit N is sampled `BAUD_DIV/2 + (N+1)*BAUD_DIV` cycles after the edge.
- `cmd_rdy` rises one cycle after the low byte's stop-bit sample.
- Reset mid-frame: the next edge with `rst_n`=0 forces `TX`=1 and drops any partial byte or command. The first falling edge seen after release is treated as a start bit.
- Baud counters are `$clog2(BAUD_DIV)+1` bits wide. They count down to 0 and reload, with no wrap beyond that.

## Test plan
All scenarios use `BAUD_DIV`=16.
- Tour command: bytes `8'h40`, `8'h22` on `RX` → `cmd`=`16'h4022`, `cmd_rdy` rises 1 cycle after the second stop sample and stays high until `clr_cmd_rdy`, then is low the next cycle.
- Move command with fanfare: bytes `8'h33`, `8'hF2` → `cmd`=`16'h33F2`. Then a calibrate command, `8'h00`, `8'h00`, sent without a clear → `cmd_rdy` drops at the calibrate's first start bit, then `cmd`=`16'h0000` and `cmd_rdy` rises again.
- Response: `send_resp` with `resp`=`8'hA5` → `TX` sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. `resp_sent` is high at cycle 160. A second `send_resp` with `8'h5A` pulsed at cycle 40 has no effect.
- Glitch rejection: `RX` low for 4 cycles → no `byte_done`, `cmd_rdy` stays 0. Framing error: high byte `8'h40` with stop=0, then bytes `8'h40`, `8'h22` → `cmd`=`16'h4022` exactly once.
- Concurrency and reset:
  - `send_resp` with `8'h5A` while receiving `8'h40`, `8'h22` → both the command and the response complete correctly.
  - `rst_n` low for 1 cycle mid-byte → `TX`=1, `cmd_rdy`=0, `resp_sent`=0. The next full command is received correctly.
